mem_tx_streamer: RTL and testbench
==================================

# mem_tx_streamer

Frame reader on the MAC-side port of the 2 KiB TX frame buffer (byte-read port A, one-cycle read latency). On a start command it fetches `tx_len` bytes from buffer address 0 upward, optionally zero-pads short frames to the 60-byte Ethernet minimum, and presents them as a valid/ready byte stream to the TX MAC. A 2-entry skid FIFO absorbs the read latency so the stream sustains one byte per cycle under arbitrary backpressure.

## Interface
- `MIN_LEN`, 60: pad target in bytes when padding is enabled (1..2048)
- `clk`  in  1  single clock; buffer read port and stream share it
- `rstn`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle command pulse; accepted only in IDLE
- `tx_len`  in  12  frame length in bytes, sampled with `start`; legal 1..2048
- `pad_en`  in  1  sampled with `start`; enables zero padding to `MIN_LEN`
- `abort`  in  1  synchronous flush, returns to IDLE
- `mem_en`  out  1  buffer read enable (drives port A enable)
- `mem_addr`  out  11  buffer byte address
- `mem_rdata`  in  8  buffer read data, valid the cycle after `mem_en`
- `tx_data`  out  8  stream byte
- `tx_valid`  out  1  stream byte valid
- `tx_last`  out  1  high with the final byte of the frame
- `tx_ready`  in  1  MAC accepts byte when `tx_valid & tx_ready`
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse after last-byte handshake

## Operation
- States: IDLE, FETCH (memory reads outstanding), PAD (zero generation), DRAIN (no new reads, FIFO emptying).
- IDLE: `start` with `tx_len` in 1..2048 -> latch `len = tx_len`, `total = pad_en ? max(tx_len, MIN_LEN) : tx_len`; clear read pointer `rd_ptr` and emitted counter; go FETCH. `start` with `tx_len == 0` or `> 2048` ignored. `start` outside IDLE ignored.
- FETCH: issue read (`mem_en=1`, `mem_addr=rd_ptr`) when `fifo_count + inflight - pop < 2`, where `pop = tx_valid & tx_ready`, `inflight` = read issued previous cycle. `rd_ptr` increments per read. After read `len-1` issued: go PAD if `total > len`, else DRAIN.
- PAD: push `0x00` into FIFO when `inflight == 0` and space as above (no `mem_en`); count pad bytes up to `total - len`; then DRAIN.
- FIFO write: `mem_rdata` pushed the cycle after each read; pushes and pops in the same cycle are legal at any occupancy; FIFO never overflows by construction.
- `tx_last` = FIFO head is byte index `total-1`; tracked by tagging the entry at push.
- DRAIN: on handshake of the `tx_last` byte -> `done` pulse next cycle, `busy` low with it, go IDLE.
- `abort` (any state): next cycle FIFO empty, `tx_valid=0`, in-flight read data discarded, state IDLE, no `done`. `abort` wins over simultaneous `start`.
- Address arithmetic 11 bits; max `len` 2048 reaches address 2047, never wraps.

## Timing
- Reset values: `mem_en=0`, `mem_addr=0`, `tx_data=0`, `tx_valid=0`, `tx_last=0`, `busy=0`, `done=0`, state IDLE, FIFO empty.
- `start` sampled at edge E0: `busy=1` and first `mem_en` (addr 0) in cycle 1; data pushed at end of cycle 2; `tx_valid=1` in cycle 3. Start-to-first-byte latency 3 cycles.
- With `tx_ready` held high: one byte per cycle, `tx_last` in cycle `total+2`, `done` in cycle `total+3`.
- `tx_valid` never drops while FIFO non-empty; `tx_data`/`tx_last` stable while `tx_valid & ~tx_ready`.
- `mem_en` deasserts for every cycle the FIFO budget is exhausted; no read is issued without a guaranteed slot.
- Next `start` accepted in the cycle `done` is high (state already IDLE).

## Test plan
- Reset mid-frame: assert `rstn=0` after 5 bytes of a 100-byte frame -> all outputs reset values immediately; new 10-byte frame afterwards streams bytes 0..9 correctly.
- Full rate: buffer preloaded with `addr[7:0]`, `tx_len=64`, `pad_en=0`, `tx_ready=1` -> bytes 0x00..0x3F in cycles 3..66, `tx_last` cycle 66, `done` cycle 67, exactly 64 `mem_en` cycles.
- Padding: `tx_len=14`, `pad_en=1` -> 14 buffer bytes then 46 × 0x00, `tx_last` on byte 59, only 14 reads issued; same with `pad_en=0` -> 14 bytes, `tx_last` on byte 13.
- Backpressure: `tx_len=2048`, random `tx_ready` (50 %) -> byte sequence matches buffer exactly, no loss or duplicate, last `mem_addr` 2047, `tx_data` stable while stalled.
- Abort: `abort` while FIFO full and a read in flight -> next cycle `tx_valid=0`, no `done`; subsequent `tx_len=1` frame emits single byte with `tx_last=1`.
- Illegal/overlapping start: `tx_len=0` -> no `busy`; `start` during a frame -> ignored, current frame completes unchanged.

Source files
------------

// File: rtl/mem_tx_streamer.sv
// Streams a frame from the TX frame buffer to the MAC as a valid/ready byte stream,
// optionally zero-padding short frames; a 2-entry skid FIFO hides the read latency.
module mem_tx_streamer #(
   parameter int unsigned MIN_LEN = 60
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic [11:0] tx_len,
   input  logic        pad_en,
   input  logic        abort,
   output logic        mem_en,
   output logic [10:0] mem_addr,
   input  logic [7:0]  mem_rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        tx_last,
   input  logic        tx_ready,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {StIdle, StFetch, StPad, StDrain} stateT;

   localparam logic [11:0] MinLen = 12'(MIN_LEN);

   stateT stateQ, stateD;

   logic [11:0] lenQ, totalQ, rdCntQ, padCntQ, pushIdxQ;
   logic        inflightQ, doneQ;

   logic [1:0][7:0] fifoDataQ;
   logic [1:0]      fifoLastQ;
   logic            fifoWrQ, fifoRdQ;
   logic [1:0]      fifoCountQ;

   logic       pop, budgetOk, startOk, memEn, padPush, pushValid, pushLast;
   logic [7:0] pushData;
   logic [2:0] occ;

   assign tx_valid = (fifoCountQ != 2'd0);
   assign tx_data  = fifoDataQ[fifoRdQ];
   assign tx_last  = tx_valid & fifoLastQ[fifoRdQ];
   assign mem_en   = memEn;
   assign mem_addr = rdCntQ[10:0];
   assign busy     = (stateQ != StIdle);
   assign done     = doneQ;

   always_comb begin
      pop     = tx_valid & tx_ready;
      // Entries held plus the read in flight must leave a slot after this cycle's pop.
      occ      = {1'b0, fifoCountQ} + {2'b00, inflightQ};
      budgetOk = occ < (3'd2 + {2'b00, pop});
      startOk  = start && (tx_len != 12'd0) && (tx_len <= 12'd2048);
      stateD   = stateQ;
      memEn    = 1'b0;
      padPush  = 1'b0;
      unique case (stateQ)
         StIdle: begin
            if (startOk) stateD = StFetch;
         end
         StFetch: begin
            if (budgetOk) begin
               memEn = 1'b1;
               if (rdCntQ == lenQ - 12'd1) stateD = (totalQ > lenQ) ? StPad : StDrain;
            end
         end
         StPad: begin
            if (!inflightQ && budgetOk) begin
               padPush = 1'b1;
               if (padCntQ == totalQ - lenQ - 12'd1) stateD = StDrain;
            end
         end
         StDrain: begin
            if (pop && tx_last) stateD = StIdle;
         end
         default: stateD = StIdle;
      endcase
      if (abort) begin
         stateD  = StIdle;
         memEn   = 1'b0;
         padPush = 1'b0;
      end
      pushValid = (inflightQ | padPush) & ~abort;
      pushData  = inflightQ ? mem_rdata : 8'h00;
      pushLast  = (pushIdxQ == totalQ - 12'd1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stateQ     <= StIdle;
         lenQ       <= '0;
         totalQ     <= '0;
         rdCntQ     <= '0;
         padCntQ    <= '0;
         pushIdxQ   <= '0;
         inflightQ  <= 1'b0;
         doneQ      <= 1'b0;
         fifoDataQ  <= '0;
         fifoLastQ  <= '0;
         fifoWrQ    <= 1'b0;
         fifoRdQ    <= 1'b0;
         fifoCountQ <= '0;
      end else begin
         stateQ    <= stateD;
         inflightQ <= memEn;
         doneQ     <= (stateQ == StDrain) & pop & tx_last & ~abort;
         if (stateQ == StIdle && startOk && !abort) begin
            lenQ     <= tx_len;
            totalQ   <= (pad_en && tx_len < MinLen) ? MinLen : tx_len;
            rdCntQ   <= '0;
            padCntQ  <= '0;
            pushIdxQ <= '0;
         end
         if (memEn) rdCntQ <= rdCntQ + 12'd1;
         if (padPush) padCntQ <= padCntQ + 12'd1;
         if (abort) begin
            fifoWrQ    <= 1'b0;
            fifoRdQ    <= 1'b0;
            fifoCountQ <= '0;
         end else begin
            if (pushValid) begin
               fifoDataQ[fifoWrQ] <= pushData;
               fifoLastQ[fifoWrQ] <= pushLast;
               fifoWrQ            <= ~fifoWrQ;
               pushIdxQ           <= pushIdxQ + 12'd1;
            end
            if (pop) fifoRdQ <= ~fifoRdQ;
            fifoCountQ <= fifoCountQ + {1'b0, pushValid} - {1'b0, pop};
         end
      end
   end

endmodule

// File: tb/tb_mem_tx_streamer.sv
// Directed bench for mem_tx_streamer: table of full-rate frames plus hand-written
// sequences for abort, reset, overlapping/illegal start and random backpressure.
module tb_mem_tx_streamer;

   logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, padEn = 1'b0, abort = 1'b0;
   logic        txReady = 1'b0;
   logic [11:0] txLen = '0;
   logic        memEn, txValid, txLast, busy, done;
   logic [10:0] memAddr;
   logic [7:0]  memRdata, txData;
   logic [7:0]  mem [2048];

   mem_tx_streamer #(.MIN_LEN(60)) dut (
      .clk(clk), .rstn(rstn), .start(start), .tx_len(txLen), .pad_en(padEn),
      .abort(abort), .mem_en(memEn), .mem_addr(memAddr), .mem_rdata(memRdata),
      .tx_data(txData), .tx_valid(txValid), .tx_last(txLast), .tx_ready(txReady),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (memEn) memRdata <= mem[memAddr];

   // Passive monitor, sampled on the falling edge.
   int          cyc = 0, memEnCnt = 0, lastAddr = 0, doneCnt = 0;
   logic [7:0]  rxData [$];
   bit          rxLast [$];
   int          rxCyc [$];
   int          doneCyc [$];

   always @(negedge clk) begin
      cyc++;
      if (rstn) begin
         if (memEn) begin
            memEnCnt++;
            lastAddr = int'(memAddr);
         end
         if (txValid && txReady) begin
            rxData.push_back(txData);
            rxLast.push_back(txLast);
            rxCyc.push_back(cyc);
         end
         if (done) begin
            doneCnt++;
            doneCyc.push_back(cyc);
         end
      end
   end

   int nCmp = 0, nFail = 0;
   int startCyc = 0, rxBase = 0, memBase = 0, doneBase = 0;

   task automatic check(input string name, input int act, input int exp);
      nCmp++;
      if (act != exp) begin
         nFail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] expByte(input int idx, input int len, input bit sel);
      logic [10:0] a;
      if (idx >= len) return 8'h00;
      a = idx[10:0];
      return sel ? (a[7:0] ^ {5'b0, a[10:8]}) : a[7:0];
   endfunction

   task automatic loadMem(input bit sel);
      for (int i = 0; i < 2048; i++) mem[i] = expByte(i, 2048, sel);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input int len, input bit pad);
      txLen    = 12'(len);
      padEn    = pad;
      start    = 1'b1;
      startCyc = cyc + 1;
      rxBase   = rxData.size();
      memBase  = memEnCnt;
      doneBase = doneCnt;
      stepCycle();
      start = 1'b0;
      padEn = 1'b0;
   endtask

   task automatic waitDone(input int budget, input bit randReady);
      bit         got = 1'b0;
      bit         prevStall = 1'b0;
      logic [7:0] prevData = '0;
      bit         prevLast = 1'b0;
      for (int i = 0; i < budget; i++) begin
         stepCycle();
         if (randReady && prevStall) begin
            check("stall_valid", int'(txValid), 1);
            check("stall_data", int'(txData), int'(prevData));
            check("stall_last", int'(txLast), int'(prevLast));
         end
         if (done) begin
            got = 1'b1;
            break;
         end
         if (randReady) begin
            txReady   = 1'($urandom_range(0, 1));
            prevStall = txValid & ~txReady;
            prevData  = txData;
            prevLast  = txLast;
         end
      end
      if (!got) check("done_timeout", 0, 1);
      txReady = 1'b1;
      stepCycle();
   endtask

   task automatic checkFrame(input int len, input int total, input int lastCyc,
                             input int doneExp, input bit sel);
      int n;
      n = rxData.size() - rxBase;
      check("byte_count", n, total);
      for (int i = 0; i < n && i < total; i++) begin
         check("byte_data", int'(rxData[rxBase + i]), int'(expByte(i, len, sel)));
         check("byte_last", int'(rxLast[rxBase + i]), int'(i == total - 1));
      end
      if (lastCyc >= 0 && n >= total) begin
         check("first_cycle", rxCyc[rxBase] - startCyc, 3);
         check("last_cycle", rxCyc[rxBase + total - 1] - startCyc, lastCyc);
      end
      check("read_count", memEnCnt - memBase, len);
      check("last_addr", lastAddr, len - 1);
      if (doneExp >= 0) begin
         if (doneCyc.size() == 0) check("done_seen", 0, 1);
         else check("done_cycle", doneCyc[doneCyc.size() - 1] - startCyc, doneExp);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      check({tag, "_mem_en"}, int'(memEn), 0);
      check({tag, "_mem_addr"}, int'(memAddr), 0);
      check({tag, "_tx_data"}, int'(txData), 0);
      check({tag, "_tx_valid"}, int'(txValid), 0);
      check({tag, "_tx_last"}, int'(txLast), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
   endtask

   typedef struct {
      int len;
      bit pad;
      int total;
      int lastCyc;
      int doneCyc;
   } vecT;

   vecT vecs [8];

   initial begin
      vecs[0] = '{64, 1'b0, 64, 66, 67};
      vecs[1] = '{14, 1'b1, 60, 62, 63};
      vecs[2] = '{14, 1'b0, 14, 16, 17};
      vecs[3] = '{1,  1'b0, 1,  3,  4};
      vecs[4] = '{1,  1'b1, 60, 62, 63};
      vecs[5] = '{60, 1'b1, 60, 62, 63};
      vecs[6] = '{61, 1'b1, 61, 63, 64};
      vecs[7] = '{59, 1'b1, 60, 62, 63};

      loadMem(1'b0);
      stepCycle();
      stepCycle();
      checkIdleOutputs("reset");
      rstn = 1'b1;
      stepCycle();
      txReady = 1'b1;

      // Full-rate frames from the table.
      foreach (vecs[k]) begin
         launch(vecs[k].len, vecs[k].pad);
         check("busy_after_start", int'(busy), 1);
         waitDone(300, 1'b0);
         checkFrame(vecs[k].len, vecs[k].total, vecs[k].lastCyc, vecs[k].doneCyc, 1'b0);
      end

      // Illegal lengths are ignored.
      memBase = memEnCnt;
      txLen = 12'd0;
      start = 1'b1;
      stepCycle();
      start = 1'b0;
      check("len0_busy", int'(busy), 0);
      txLen = 12'd2049;
      start = 1'b1;
      stepCycle();
      start = 1'b0;
      check("len2049_busy", int'(busy), 0);
      repeat (3) stepCycle();
      check("illegal_no_reads", memEnCnt - memBase, 0);

      // Start during a frame is ignored.
      launch(20, 1'b0);
      repeat (4) stepCycle();
      txLen = 12'd5;
      padEn = 1'b1;
      start = 1'b1;
      stepCycle();
      start = 1'b0;
      padEn = 1'b0;
      check("overlap_busy", int'(busy), 1);
      waitDone(200, 1'b0);
      checkFrame(20, 20, 22, 23, 1'b0);

      // Back-to-back: next start accepted in the done cycle.
      launch(3, 1'b0);
      for (int i = 0; i < 50 && !done; i++) stepCycle();
      check("b2b_done_seen", int'(done), 1);
      launch(2, 1'b0);
      check("b2b_busy", int'(busy), 1);
      waitDone(50, 1'b0);
      checkFrame(2, 2, 4, 5, 1'b0);

      // Abort with the FIFO full.
      txReady = 1'b0;
      launch(100, 1'b0);
      repeat (3) stepCycle();
      check("abort_prefull_valid", int'(txValid), 1);
      abort = 1'b1;
      stepCycle();
      abort = 1'b0;
      check("abort_full_valid", int'(txValid), 0);
      check("abort_full_busy", int'(busy), 0);
      txReady = 1'b1;
      repeat (5) stepCycle();
      check("abort_full_no_done", doneCnt - doneBase, 0);
      check("abort_full_no_bytes", rxData.size() - rxBase, 0);

      // Abort with a read in flight: its data must be discarded.
      launch(100, 1'b0);
      stepCycle();
      abort = 1'b1;
      stepCycle();
      abort = 1'b0;
      check("abort_inflight_valid", int'(txValid), 0);
      repeat (4) stepCycle();
      check("abort_inflight_no_bytes", rxData.size() - rxBase, 0);
      check("abort_inflight_no_done", doneCnt - doneBase, 0);

      // Abort beats a simultaneous start.
      txLen = 12'd5;
      start = 1'b1;
      abort = 1'b1;
      stepCycle();
      start = 1'b0;
      abort = 1'b0;
      check("abort_start_busy", int'(busy), 0);

      launch(1, 1'b0);
      waitDone(50, 1'b0);
      checkFrame(1, 1, 3, 4, 1'b0);

      // Reset in the middle of a frame.
      launch(100, 1'b0);
      for (int i = 0; i < 50 && (rxData.size() - rxBase) < 5; i++) stepCycle();
      rstn = 1'b0;
      #1;
      checkIdleOutputs("midreset");
      stepCycle();
      rstn = 1'b1;
      stepCycle();
      launch(10, 1'b0);
      waitDone(100, 1'b0);
      checkFrame(10, 10, 12, 13, 1'b0);

      // Maximum length under random backpressure.
      loadMem(1'b1);
      launch(2048, 1'b0);
      waitDone(20000, 1'b1);
      checkFrame(2048, 2048, -1, -1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
